seq_divider: RTL and testbench

- Parametrised iterative radix-2 restoring divider. Successor to the fixed 64-bit IP-wrapped divider.
- Adds a start/busy/done handshake, a configurable width, signed or unsigned mode, a fixed-point fractional quotient, a remainder output, overflow saturation and abort.
- Used by the kinematics datapath wherever a quotient is needed without a vendor IP core. Latency is deterministic.

---
 rtl/div_pkg.sv | 7 +
 rtl/div_sign_fix.sv | 27 ++
 rtl/seq_divider.sv | 137 +++++++++++++
 tb/tb_seq_divider.sv | 129 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and counter sizing for the sequential divider.
package div_pkg;
   typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional negation of a magnitude and a secondary value, plus
// the saturation value and range check of the magnitude against WIDTH.
module div_sign_fix #(
   parameter int WIDTH  = 32,
   parameter int IW     = 32,
   parameter bit SIGNED = 1
) (
   input  logic [IW-1:0]    val,
   input  logic             neg,
   input  logic [WIDTH-1:0] rval,
   input  logic             rneg,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] rres,
   output logic [WIDTH-1:0] sat,
   output logic             ovf
);
   localparam logic [IW:0] ONE = (IW+1)'(1);
   logic [IW:0] lim;
   always_comb begin
      res  = neg ? -val[WIDTH-1:0] : val[WIDTH-1:0];
      rres = rneg ? -rval : rval;
      // a negative result may reach one past the positive limit
      lim  = SIGNED ? (ONE << (WIDTH-1)) - (IW+1)'(!neg) : (ONE << WIDTH) - ONE;
      ovf  = {1'b0, val} > lim;
      sat  = SIGNED ? (neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : '1;
   end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider with start/busy/done handshake,
// signed/unsigned mode, fixed-point quotient, saturation and abort.
module seq_divider import div_pkg::*; #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED    = 1,
   parameter int FRAC_BITS = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);
   localparam int N  = WIDTH + FRAC_BITS;
   localparam int CW = cnt_width(N);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, rmd_q, rmd_d;
   logic [N-1:0] sh_q, sh_d;
   logic qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;
   logic [N-1:0] fx_val;
   logic [WIDTH-1:0] fx_rval, fx_res, fx_rres, fx_sat;
   logic fx_neg, fx_rneg, fx_ovf, prep, a_neg, b_neg, ge;
   logic [WIDTH:0] rem_s;
   // one sign unit shared: operand magnitudes in PREP, result signs in FIX
   div_sign_fix #(.WIDTH(WIDTH), .IW(N), .SIGNED(SIGNED)) u_fix (
      .val(fx_val), .neg(fx_neg), .rval(fx_rval), .rneg(fx_rneg),
      .res(fx_res), .rres(fx_rres), .sat(fx_sat), .ovf(fx_ovf)
   );
   always_comb begin
      prep    = state_q == PREP;
      a_neg   = SIGNED && a_q[WIDTH-1];
      b_neg   = SIGNED && b_q[WIDTH-1];
      fx_val  = prep ? N'(a_q) : sh_q;
      fx_neg  = prep ? a_neg : qneg_q;
      fx_rval = prep ? b_q : rem_q;
      fx_rneg = prep ? b_neg : rneg_q;
      rem_s   = {rem_q, sh_q[N-1]};
      ge      = rem_s >= {1'b0, b_q};
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      sh_d    = sh_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      if (abort && state_q != IDLE) state_d = IDLE;
      else case (state_q)
         IDLE: if (start) begin
            a_d     = dividend;
            b_d     = divisor;
            state_d = PREP;
         end
         PREP: begin
            sh_d    = N'(fx_res) << FRAC_BITS;
            b_d     = fx_rres;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            rem_d   = '0;
            cnt_d   = '0;
            dz_d    = b_q == '0;
            state_d = (b_q == '0) ? FIX : ITER;
         end
         ITER: begin
            rem_d   = ge ? rem_s[WIDTH-1:0] - b_q : rem_s[WIDTH-1:0];
            sh_d    = {sh_q[N-2:0], ge};
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(N-1)) ? FIX : ITER;
         end
         FIX: begin
            done_d  = 1'b1;
            dbz_d   = dz_q;
            ovf_d   = !dz_q && fx_ovf;
            quo_d   = (dz_q || fx_ovf) ? fx_sat : fx_res;
            rmd_d   = dz_q ? a_q : fx_rres;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         sh_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         sh_q    <= sh_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy        = state_q != IDLE;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider in signed, unsigned and fixed-point builds.
module tb_seq_divider;
   logic clk = 1'b0;
   logic reset, abort;
   logic [15:0] dvd, dvs;
   logic [2:0] st, bsy, dn, dz, ov;
   logic [15:0] q [3];
   logic [15:0] r [3];
   int pass_n = 0, fail_n = 0, total_n = 0, lat = 0;
   bit busy_ok;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(16), .SIGNED(1), .FRAC_BITS(0)) u_s (
      .clk(clk), .reset(reset), .start(st[0]), .abort(abort), .dividend(dvd), .divisor(dvs),
      .busy(bsy[0]), .done(dn[0]), .quotient(q[0]), .remainder(r[0]), .div_by_zero(dz[0]), .overflow(ov[0]));
   seq_divider #(.WIDTH(16), .SIGNED(0), .FRAC_BITS(0)) u_u (
      .clk(clk), .reset(reset), .start(st[1]), .abort(abort), .dividend(dvd), .divisor(dvs),
      .busy(bsy[1]), .done(dn[1]), .quotient(q[1]), .remainder(r[1]), .div_by_zero(dz[1]), .overflow(ov[1]));
   seq_divider #(.WIDTH(16), .SIGNED(1), .FRAC_BITS(8)) u_f (
      .clk(clk), .reset(reset), .start(st[2]), .abort(abort), .dividend(dvd), .divisor(dvs),
      .busy(bsy[2]), .done(dn[2]), .quotient(q[2]), .remainder(r[2]), .div_by_zero(dz[2]), .overflow(ov[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_n++;
      assert (obs === exp) pass_n++;
      else begin
         fail_n++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // poke 1 re-pulses start with other operands, poke 2 pulses abort, both at cycle poke_at
   task automatic run(input int d, input logic [15:0] a, input logic [15:0] b, input int poke, input int poke_at);
      dvd = a;
      dvs = b;
      @(negedge clk);
      st[d] = 1'b1;
      @(posedge clk);
      #1 st[d] = 1'b0;
      busy_ok = bsy[d];
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         st[d] = 1'b0;
         abort = 1'b0;
         lat++;
         if (dn[d]) break;
         busy_ok &= bsy[d];
         if (lat == poke_at && poke == 1) begin
            dvd = 16'd9;
            dvs = 16'd3;
            st[d] = 1'b1;
         end
         if (lat == poke_at && poke == 2) abort = 1'b1;
      end
   endtask

   task automatic result(input int d, input string tag, input int elat, input logic [15:0] eq,
                         input logic [15:0] er, input logic edz, input logic eov);
      chk({tag, " latency"}, 64'(lat), 64'(elat));
      chk({tag, " quotient"}, 64'(q[d]), 64'(eq));
      chk({tag, " remainder"}, 64'(r[d]), 64'(er));
      chk({tag, " dz/ovf"}, {62'd0, dz[d], ov[d]}, {62'd0, edz, eov});
      chk({tag, " busy until done"}, 64'({busy_ok, bsy[d]}), 64'(2'b10));
      @(posedge clk);
      #1 chk({tag, " done pulse"}, 64'(dn[d]), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      abort = 1'b0;
      st = '0;
      dvd = '0;
      dvs = '0;
      #12;
      chk("reset state", {bsy[0], dn[0], dz[0], ov[0], q[0], r[0]}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run(0, 16'd100, 16'd7, 0, 0);
      result(0, "100/7", 18, 16'd14, 16'd2, 1'b0, 1'b0);
      run(0, -16'sd100, 16'd7, 0, 0);
      result(0, "-100/7", 18, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
      run(0, 16'd100, -16'sd7, 0, 0);
      result(0, "100/-7", 18, 16'hFFF2, 16'h0002, 1'b0, 1'b0);
      run(0, 16'd5, 16'd0, 0, 0);
      result(0, "5/0", 2, 16'h7FFF, 16'h0005, 1'b1, 1'b0);
      run(0, -16'sd5, 16'd0, 0, 0);
      result(0, "-5/0", 2, 16'h8000, 16'hFFFB, 1'b1, 1'b0);
      run(0, 16'h8000, 16'hFFFF, 0, 0);
      result(0, "MIN/-1", 18, 16'h7FFF, 16'h0000, 1'b0, 1'b1);

      run(1, 16'hFFFF, 16'h0001, 0, 0);
      result(1, "unsigned FFFF/1", 18, 16'hFFFF, 16'h0000, 1'b0, 1'b0);

      run(2, 16'd3, 16'd2, 0, 0);
      result(2, "frac 3/2", 26, 16'h0180, 16'h0000, 1'b0, 1'b0);
      run(2, 16'd200, 16'd1, 0, 0);
      result(2, "frac 200/1", 26, 16'h7FFF, 16'h0000, 1'b0, 1'b1);

      run(0, 16'd100, 16'd7, 1, 5);
      result(0, "start in ITER", 18, 16'd14, 16'd2, 1'b0, 1'b0);

      run(0, 16'd50, 16'd5, 2, 5);
      chk("abort no done", 64'(lat), 64'd100);
      chk("abort busy", 64'(bsy[0]), 64'd0);
      chk("abort keeps quotient", 64'(q[0]), 64'd14);

      dvd = 16'd50;
      dvs = 16'd5;
      @(negedge clk);
      st[0] = 1'b1;
      @(posedge clk);
      #1 st[0] = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1 chk("async reset mid-ITER", {bsy[0], dn[0], dz[0], ov[0], q[0], r[0]}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run(0, 16'd100, 16'd7, 0, 0);
      result(0, "100/7 after reset", 18, 16'd14, 16'd2, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
